edid_hpd_controller: RTL

- Sequences the EDID EEPROM's write port (addr/data/wr) and the HDMI hot-plug-detect line.
- After reset, copies a g_size-byte default EDID image from a synchronous ROM into the EEPROM, optionally replacing the last byte with a computed checksum, then asserts HPD.
- Afterwards, arbitrates host-bus writes onto the same port. On host commit, pulses HPD low so the sink re-reads the EDID.

---
 rtl/edid_hpd_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/edid_hpd_controller.sv
// EDID EEPROM write sequencer: copies the default image from ROM after reset,
// then forwards host writes and drives HDMI hot-plug-detect.
module edid_hpd_controller #(
    parameter int unsigned g_size           = 128,
    parameter bit          g_auto_checksum  = 1'b1,
    parameter logic [15:0] g_hpd_low_cycles = 16'd50000
) (
    input  logic       clk_sys_i,
    input  logic       rst_i,
    output logic [7:0] rom_addr_o,
    input  logic [7:0] rom_data_i,
    input  logic [7:0] host_addr_i,
    input  logic [7:0] host_data_i,
    input  logic       host_wr_i,
    output logic       host_ready_o,
    input  logic       host_commit_i,
    input  logic       hdmi_p5v_i,
    output logic [7:0] edid_addr_o,
    output logic [7:0] edid_data_o,
    output logic       edid_wr_o,
    output logic       hpd_o,
    output logic       busy_o
);

    localparam logic [7:0] LAST_ADDR = 8'(g_size - 1);

    typedef enum logic [1:0] {
        ST_COPY     = 2'd0,
        ST_HPD_WAIT = 2'd1,
        ST_READY    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic        issue_done_q, issue_done_d;
    logic [7:0]  edid_addr_q, edid_addr_d;
    logic [7:0]  edid_data_q, edid_data_d;
    logic        edid_wr_q, edid_wr_d;
    logic        hpd_q, hpd_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [1:0]  p5v_sync_q, p5v_sync_d;
    logic        commit_pending_q, commit_pending_d;
    logic [15:0] cnt_q, cnt_d;

    logic p5v_s;
    logic copy_wr_c;
    logic last_copy_c;

    assign p5v_s = p5v_sync_q[1];

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_COPY;
            rom_addr_q       <= 8'd0;
            issue_done_q     <= 1'b0;
            edid_addr_q      <= 8'd0;
            edid_data_q      <= 8'd0;
            edid_wr_q        <= 1'b0;
            hpd_q            <= 1'b0;
            checksum_q       <= 8'd0;
            p5v_sync_q       <= 2'b00;
            commit_pending_q <= 1'b0;
            cnt_q            <= 16'd0;
        end else begin
            state_q          <= state_d;
            rom_addr_q       <= rom_addr_d;
            issue_done_q     <= issue_done_d;
            edid_addr_q      <= edid_addr_d;
            edid_data_q      <= edid_data_d;
            edid_wr_q        <= edid_wr_d;
            hpd_q            <= hpd_d;
            checksum_q       <= checksum_d;
            p5v_sync_q       <= p5v_sync_d;
            commit_pending_q <= commit_pending_d;
            cnt_q            <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        rom_addr_d       = rom_addr_q;
        issue_done_d     = issue_done_q;
        edid_addr_d      = edid_addr_q;
        edid_data_d      = edid_data_q;
        edid_wr_d        = 1'b0;
        checksum_d       = checksum_q;
        p5v_sync_d       = {p5v_sync_q[0], hdmi_p5v_i};
        commit_pending_d = commit_pending_q;
        cnt_d            = cnt_q;

        case (state_q)
            ST_COPY: begin
                if (host_commit_i) commit_pending_d = 1'b1;
                // Issue side: one ROM address per cycle, write lands a cycle later
                if (!issue_done_q) begin
                    edid_wr_d   = 1'b1;
                    edid_addr_d = rom_addr_q;
                    if (rom_addr_q == LAST_ADDR) issue_done_d = 1'b1;
                    else rom_addr_d = rom_addr_q + 8'd1;
                end
                if (edid_wr_q && edid_addr_q != LAST_ADDR)
                    checksum_d = checksum_q + rom_data_i;
                if (edid_wr_q && edid_addr_q == LAST_ADDR) begin
                    state_d          = ST_HPD_WAIT;
                    cnt_d            = g_hpd_low_cycles;
                    commit_pending_d = 1'b0;
                end
            end
            ST_HPD_WAIT: begin
                edid_wr_d = host_wr_i;
                if (host_wr_i) begin
                    edid_addr_d = host_addr_i;
                    edid_data_d = host_data_i;
                end
                if (host_commit_i) cnt_d = g_hpd_low_cycles;
                else if (cnt_q <= 16'd1) state_d = ST_READY;
                else cnt_d = cnt_q - 16'd1;
            end
            ST_READY: begin
                edid_wr_d = host_wr_i;
                if (host_wr_i) begin
                    edid_addr_d = host_addr_i;
                    edid_data_d = host_data_i;
                end
                if (host_commit_i) begin
                    state_d = ST_HPD_WAIT;
                    cnt_d   = g_hpd_low_cycles;
                end
            end
            default: state_d = ST_COPY;
        endcase

        // Based on next state so the low time equals the HPD_WAIT dwell exactly
        hpd_d = (state_d == ST_READY) && p5v_s;
    end

    // Copy writes take ROM data straight from the synchronous ROM's output
    assign copy_wr_c   = (state_q == ST_COPY) && edid_wr_q;
    assign last_copy_c = g_auto_checksum && (edid_addr_q == LAST_ADDR);

    always_comb begin
        edid_data_o = edid_data_q;
        if (copy_wr_c) edid_data_o = last_copy_c ? 8'(8'd0 - checksum_q) : rom_data_i;
    end

    assign rom_addr_o   = rom_addr_q;
    assign edid_addr_o  = edid_addr_q;
    assign edid_wr_o    = edid_wr_q;
    assign hpd_o        = hpd_q;
    assign host_ready_o = (state_q != ST_COPY);
    assign busy_o       = (state_q != ST_READY);

endmodule
